key_irq_master: RTL and testbench

//  Avalon-MM initiator that services the 4-register PIO key slave: programs irq_mask,

---
 rtl/key_irq_master.sv | 161 ++++++++++++++++
 tb/tb_key_irq_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_irq_master.sv
// rtl/key_irq_master.sv - Avalon-MM initiator servicing a PIO key slave and emitting key events
module key_irq_master #(
    parameter int WIDTH        = 2,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       address,
    output logic             chipselect,
    output logic             write_n,
    output logic [31:0]      writedata,
    input  logic [31:0]      readdata,
    input  logic             irq,
    input  logic [WIDTH-1:0] cfg_mask,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_level,
    output logic [CNT_W-1:0] evt_count
);

    typedef enum logic [2:0] {
        S_INIT, S_WR_MASK, S_IDLE, S_RD_EDGE, S_WR_CLR, S_RD_DATA, S_PUSH
    } state_t;

    localparam int             CW      = $clog2(READ_LATENCY + 2);
    localparam logic [CW-1:0]  RD_LAST = CW'(READ_LATENCY);

    state_t           state_q, state_d;
    logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [1:0]       address_q, address_d;
    logic             chipselect_q, chipselect_d;
    logic             write_n_q, write_n_d;
    logic [31:0]      writedata_q, writedata_d;
    logic             evt_valid_q, evt_valid_d;
    logic [WIDTH-1:0] evt_edges_q, evt_edges_d;
    logic [WIDTH-1:0] evt_level_q, evt_level_d;
    logic [CNT_W-1:0] evt_count_q, evt_count_d;
    logic [WIDTH-1:0] mask_shadow_q, mask_shadow_d;
    logic [WIDTH-1:0] edges_q, edges_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic             rd_done;
    logic [31-WIDTH:0] rd_unused;

    assign rd_unused = readdata[31:WIDTH];
    assign rd_done   = (rd_cnt_q == RD_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_INIT;
            rd_cnt_q      <= '0;
            address_q     <= 2'd0;
            chipselect_q  <= 1'b0;
            write_n_q     <= 1'b1;
            writedata_q   <= 32'd0;
            evt_valid_q   <= 1'b0;
            evt_edges_q   <= '0;
            evt_level_q   <= '0;
            evt_count_q   <= '0;
            mask_shadow_q <= '0;
            edges_q       <= '0;
            level_q       <= '0;
        end else begin
            state_q       <= state_d;
            rd_cnt_q      <= rd_cnt_d;
            address_q     <= address_d;
            chipselect_q  <= chipselect_d;
            write_n_q     <= write_n_d;
            writedata_q   <= writedata_d;
            evt_valid_q   <= evt_valid_d;
            evt_edges_q   <= evt_edges_d;
            evt_level_q   <= evt_level_d;
            evt_count_q   <= evt_count_d;
            mask_shadow_q <= mask_shadow_d;
            edges_q       <= edges_d;
            level_q       <= level_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        edges_d       = edges_q;
        level_d       = level_q;
        mask_shadow_d = mask_shadow_q;
        evt_valid_d   = evt_valid_q;
        evt_edges_d   = evt_edges_q;
        evt_level_d   = evt_level_q;
        evt_count_d   = evt_count_q;

        if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
            evt_count_d = evt_count_q + CNT_W'(1);
        end

        case (state_q)
            S_INIT:    state_d = S_WR_MASK;
            S_WR_MASK: state_d = S_IDLE;
            S_IDLE: begin
                // a pending mask update wins over a pending interrupt
                if (cfg_mask != mask_shadow_q)  state_d = S_WR_MASK;
                else if (irq && !evt_valid_q)   state_d = S_RD_EDGE;
            end
            S_RD_EDGE: begin
                if (rd_done) begin
                    edges_d = readdata[WIDTH-1:0] & mask_shadow_q;
                    state_d = S_WR_CLR;
                end
            end
            S_WR_CLR:  state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (rd_done) begin
                    level_d = readdata[WIDTH-1:0];
                    state_d = (edges_q != '0) ? S_PUSH : S_IDLE;
                end
            end
            S_PUSH: begin
                evt_valid_d = 1'b1;
                evt_edges_d = edges_q;
                evt_level_d = level_q;
                state_d     = S_IDLE;
            end
            default:   state_d = S_INIT;
        endcase

        rd_cnt_d = (state_d == state_q) ? rd_cnt_q + CW'(1) : '0;

        // bus signals are registered, so they follow the state being entered
        address_d    = address_q;
        chipselect_d = 1'b0;
        write_n_d    = 1'b1;
        writedata_d  = 32'd0;
        case (state_d)
            S_WR_MASK: begin
                address_d     = 2'd2;
                chipselect_d  = 1'b1;
                write_n_d     = 1'b0;
                writedata_d   = {{(32-WIDTH){1'b0}}, cfg_mask};
                mask_shadow_d = cfg_mask;
            end
            S_RD_EDGE: address_d = 2'd3;
            S_WR_CLR: begin
                address_d    = 2'd3;
                chipselect_d = 1'b1;
                write_n_d    = 1'b0;
            end
            S_RD_DATA: address_d = 2'd0;
            default: ;
        endcase
    end

    assign address    = address_q;
    assign chipselect = chipselect_q;
    assign write_n    = write_n_q;
    assign writedata  = writedata_q;
    assign evt_valid  = evt_valid_q;
    assign evt_edges  = evt_edges_q;
    assign evt_level  = evt_level_q;
    assign evt_count  = evt_count_q;

endmodule

// File: tb/tb_key_irq_master.sv
// tb/tb_key_irq_master.sv - directed bench for key_irq_master with a PIO key slave model
module tb_key_irq_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [1:0]  cfg_mask;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_edges;
    logic [1:0]  evt_level;
    logic [15:0] evt_count;

    logic [1:0]  keys, keys_prev, s_mask, s_edge;
    logic        clr_edges, force_irq;
    logic [7:0]  bus_log[$];
    logic [1:0]  prev_addr;
    int          wd_hi_err = 0;
    int          vec = 0;
    int          err = 0;

    always #5 clk = ~clk;

    key_irq_master #(.WIDTH(2), .READ_LATENCY(1), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .cfg_mask(cfg_mask), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_edges(evt_edges), .evt_level(evt_level), .evt_count(evt_count)
    );

    // PIO key slave: falling-edge capture, registered readdata, write to 3 clears all
    always @(posedge clk) begin
        if (!reset_n) begin
            s_mask    <= 2'b00;
            s_edge    <= 2'b00;
            keys_prev <= keys;
            readdata  <= 32'd0;
        end else begin
            keys_prev <= keys;
            case (address)
                2'd0:    readdata <= {30'd0, keys};
                2'd2:    readdata <= {30'd0, s_mask};
                2'd3:    readdata <= {30'd0, s_edge};
                default: readdata <= 32'd0;
            endcase
            if (chipselect && !write_n && address == 2'd2) s_mask <= writedata[1:0];
            if ((chipselect && !write_n && address == 2'd3) || clr_edges)
                s_edge <= keys_prev & ~keys;
            else
                s_edge <= s_edge | (keys_prev & ~keys);
        end
    end
    assign irq = (|(s_edge & s_mask)) | force_irq;

    // bus log entry: {is_write, 0, address, writedata[3:0]}; reads seen as address changes
    always begin
        @(posedge clk);
        #2;
        if (reset_n) begin
            if (chipselect && !write_n) begin
                bus_log.push_back({1'b1, 1'b0, address, writedata[3:0]});
                if (writedata[31:2] != 30'd0) wd_hi_err++;
            end else if (address != prev_addr) begin
                bus_log.push_back({2'b00, address, 4'h0});
            end
        end
        prev_addr = address;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!evt_valid && n < budget) begin
            tick(1);
            n++;
        end
        if (!evt_valid) n = -1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; cfg_mask = 2'b11; keys = 2'b11; evt_ready = 1'b1;
        force_irq = 1'b0; clr_edges = 1'b0;
        tick(3);
        vec++;
        if ({address, chipselect, write_n, writedata, evt_valid, evt_edges, evt_level, evt_count}
            !== {2'd0, 1'b0, 1'b1, 32'd0, 1'b0, 2'd0, 2'd0, 16'd0}) begin
            err++;
            $display("FAIL reset_values got a=%0d cs=%0b wn=%0b wd=%0h v=%0b e=%0b l=%0b c=%0d",
                     address, chipselect, write_n, writedata, evt_valid, evt_edges, evt_level, evt_count);
        end
        bus_log.delete();
        reset_n = 1'b1;
        tick(1);
        vec++;
        if ({chipselect, write_n, address, writedata} !== {1'b1, 1'b0, 2'd2, 32'h3}) begin
            err++;
            $display("FAIL init_mask_write got cs=%0b wn=%0b a=%0d wd=%0h want cs=1 wn=0 a=2 wd=3",
                     chipselect, write_n, address, writedata);
        end
        tick(1);
        vec++;
        if ({chipselect, write_n} !== 2'b01) begin
            err++;
            $display("FAIL init_write_end got cs=%0b wn=%0b want cs=0 wn=1", chipselect, write_n);
        end
        tick(10);
        vec++;
        if (bus_log.size() != 1 || bus_log[0] !== 8'hA3) begin
            err++;
            $display("FAIL init_bus_log got size=%0d first=%0h want size=1 first=a3",
                     bus_log.size(), bus_log.size() > 0 ? bus_log[0] : 8'h00);
        end
    endtask

    task automatic test_single_event;
        int n;
        bus_log.delete();
        keys = 2'b10;
        tick(1);
        vec++;
        if (irq !== 1'b1) begin
            err++;
            $display("FAIL single_irq got %0b want 1", irq);
        end
        wait_valid(20, n);
        vec++;
        if (n != 7) begin
            err++;
            $display("FAIL single_latency got %0d want 7", n);
        end
        vec++;
        if ({evt_edges, evt_level, evt_count} !== {2'b01, 2'b10, 16'd0}) begin
            err++;
            $display("FAIL single_payload got e=%0b l=%0b c=%0d want e=01 l=10 c=0",
                     evt_edges, evt_level, evt_count);
        end
        tick(1);
        vec++;
        if ({evt_valid, evt_count} !== {1'b0, 16'd1}) begin
            err++;
            $display("FAIL single_accept got v=%0b c=%0d want v=0 c=1", evt_valid, evt_count);
        end
        vec++;
        if (bus_log.size() != 3 || {bus_log[0], bus_log[1], bus_log[2]} !== 24'h30B000) begin
            err++;
            $display("FAIL single_bus_seq got size=%0d want rd3 wr3 rd0 (30 b0 00)", bus_log.size());
        end
        keys = 2'b11;
        tick(3);
    endtask

    task automatic test_back_to_back;
        int n;
        evt_ready = 1'b0;
        bus_log.delete();
        keys = 2'b10; tick(1);
        keys = 2'b11; tick(1);
        keys = 2'b10;
        wait_valid(20, n);
        vec++;
        if (n < 0 || {evt_edges, evt_level} !== {2'b01, 2'b10}) begin
            err++;
            $display("FAIL bp_first_event got n=%0d e=%0b l=%0b want e=01 l=10", n, evt_edges, evt_level);
        end
        keys = 2'b00;
        tick(10);
        vec++;
        if ({evt_valid, evt_edges, evt_level, irq} !== {1'b1, 2'b01, 2'b10, 1'b1}) begin
            err++;
            $display("FAIL bp_hold got v=%0b e=%0b l=%0b irq=%0b want v=1 e=01 l=10 irq=1",
                     evt_valid, evt_edges, evt_level, irq);
        end
        vec++;
        if (bus_log.size() != 3) begin
            err++;
            $display("FAIL bp_no_service got bus entries=%0d want 3", bus_log.size());
        end
        evt_ready = 1'b1;
        tick(1);
        vec++;
        if (evt_count !== 16'd2) begin
            err++;
            $display("FAIL bp_count1 got %0d want 2", evt_count);
        end
        wait_valid(20, n);
        vec++;
        if (n < 0 || {evt_edges, evt_level} !== {2'b10, 2'b00}) begin
            err++;
            $display("FAIL bp_second_event got n=%0d e=%0b l=%0b want e=10 l=00", n, evt_edges, evt_level);
        end
        tick(1);
        vec++;
        if ({evt_valid, evt_count} !== {1'b0, 16'd3}) begin
            err++;
            $display("FAIL bp_count2 got v=%0b c=%0d want v=0 c=3", evt_valid, evt_count);
        end
        keys = 2'b11;
        tick(3);
    endtask

    task automatic test_mask_filter;
        logic irq_seen, valid_seen;
        bus_log.delete();
        cfg_mask = 2'b01;
        tick(4);
        vec++;
        if (bus_log.size() != 1 || bus_log[0] !== 8'hA1) begin
            err++;
            $display("FAIL mask_rewrite got size=%0d want one write a1", bus_log.size());
        end
        bus_log.delete();
        keys = 2'b01;
        irq_seen = 1'b0;
        valid_seen = 1'b0;
        repeat (15) begin
            tick(1);
            if (irq) irq_seen = 1'b1;
            if (evt_valid) valid_seen = 1'b1;
        end
        vec++;
        if ({irq_seen, valid_seen} !== 2'b00 || bus_log.size() != 0) begin
            err++;
            $display("FAIL mask_filter got irq=%0b valid=%0b bus=%0d want 0 0 0",
                     irq_seen, valid_seen, bus_log.size());
        end
        vec++;
        if (evt_count !== 16'd3) begin
            err++;
            $display("FAIL mask_count got %0d want 3", evt_count);
        end
        keys = 2'b11;
        tick(2);
    endtask

    task automatic test_spurious;
        logic valid_seen;
        clr_edges = 1'b1; tick(1); clr_edges = 1'b0;
        bus_log.delete();
        force_irq = 1'b1; tick(1); force_irq = 1'b0;
        valid_seen = 1'b0;
        repeat (12) begin
            tick(1);
            if (evt_valid) valid_seen = 1'b1;
        end
        vec++;
        if (bus_log.size() != 3 || {bus_log[0], bus_log[1], bus_log[2]} !== 24'h30B000) begin
            err++;
            $display("FAIL spurious_bus_seq got size=%0d want rd3 wr3 rd0", bus_log.size());
        end
        vec++;
        if ({valid_seen, evt_count} !== {1'b0, 16'd3}) begin
            err++;
            $display("FAIL spurious_no_event got v=%0b c=%0d want v=0 c=3", valid_seen, evt_count);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        cfg_mask = 2'b11;
        tick(4);
        keys = 2'b10;
        n = 0;
        while (!(chipselect && !write_n && address == 2'd3) && n < 20) begin
            tick(1);
            n++;
        end
        vec++;
        if (n >= 20) begin
            err++;
            $display("FAIL mid_wait_clear got timeout want wr3");
        end
        tick(1);
        vec++;
        if (address !== 2'd0) begin
            err++;
            $display("FAIL mid_rd_data got a=%0d want 0", address);
        end
        reset_n = 1'b0;
        tick(1);
        vec++;
        if ({address, chipselect, write_n, writedata, evt_valid, evt_edges, evt_level, evt_count}
            !== {2'd0, 1'b0, 1'b1, 32'd0, 1'b0, 2'd0, 2'd0, 16'd0}) begin
            err++;
            $display("FAIL mid_reset_values got a=%0d cs=%0b wn=%0b wd=%0h v=%0b c=%0d",
                     address, chipselect, write_n, writedata, evt_valid, evt_count);
        end
        bus_log.delete();
        reset_n = 1'b1;
        tick(1);
        vec++;
        if ({chipselect, write_n, address, writedata} !== {1'b1, 1'b0, 2'd2, 32'h3}) begin
            err++;
            $display("FAIL mid_mask_first got cs=%0b wn=%0b a=%0d wd=%0h want 1 0 2 3",
                     chipselect, write_n, address, writedata);
        end
        tick(10);
        vec++;
        if (bus_log.size() != 1 || bus_log[0] !== 8'hA3 || evt_valid !== 1'b0) begin
            err++;
            $display("FAIL mid_after_release got size=%0d v=%0b want size=1 v=0", bus_log.size(), evt_valid);
        end
        vec++;
        if (wd_hi_err != 0) begin
            err++;
            $display("FAIL writedata_upper got %0d nonzero writes want 0", wd_hi_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_back_to_back();
        test_mask_filter();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
